// File: rtl/pdm_tx_pkg.sv
// Shared types and arithmetic helpers for the PCM-to-PDM transmitter.
package pdm_tx_pkg;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned acc_ext);
    return data_width + acc_ext;
  endfunction

  function automatic longint full_scale(input int unsigned data_width);
    return longint'(1) <<< (data_width - 1);
  endfunction

  // Symmetric clamp to +/-(2^(w-1)-1) so the integrators never wrap.
  function automatic longint sat_add(input longint a, input longint b,
                                     input int unsigned w);
    longint lim;
    longint s;
    lim = (longint'(1) <<< (w - 1)) - 1;
    s   = a + b;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

endpackage

// File: rtl/pdm_sd2_mod.sv
// One step of the 2nd-order sigma-delta modulator (purely combinational).
module pdm_sd2_mod
  import pdm_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_EXT    = 4,
  localparam int unsigned W         = DATA_WIDTH + ACC_EXT
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [W-1:0]          i1,
  input  logic signed [W-1:0]          i2,
  input  logic                         y,
  output logic signed [W-1:0]          i1_next,
  output logic signed [W-1:0]          i2_next,
  output logic                         y_next
);

  localparam longint FS = full_scale(DATA_WIDTH);

  longint xe;
  longint fb;
  longint i1_s;
  longint i2_s;

  always_comb begin
    xe      = longint'(x);
    fb      = y ? FS : -FS;
    i1_s    = sat_add(longint'(i1), xe - fb, W);
    i2_s    = sat_add(longint'(i2), i1_s - fb, W);
    i1_next = W'(i1_s);
    i2_next = W'(i2_s);
    y_next  = (i2_s >= 0);
  end

endmodule

// File: rtl/pdm_tx.sv
// PCM-to-PDM transmitter: stream buffering, PDM clock divider, zero-order
// hold and a shared 2nd-order modulator time-multiplexed across channels.
module pdm_tx
  import pdm_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_EXT    = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_stereo_i,
  input  logic [7:0]            cfg_clkdiv_i,
  input  logic [9:0]            cfg_oversample_i,
  input  logic [DATA_WIDTH-1:0] pcm_data_i,
  input  logic                  pcm_data_valid_i,
  output logic                  pcm_data_ready_o,
  output logic                  pdm_clk_o,
  output logic                  pdm_data_o,
  output logic                  underrun_o
);

  localparam int unsigned W = acc_width(DATA_WIDTH, ACC_EXT);

  logic [7:0]            div_cnt;
  logic [9:0]            os_cnt;
  logic [9:0]            os_last;
  logic                  started;
  logic [DATA_WIDTH-1:0] cur [2];
  logic [DATA_WIDTH-1:0] nxt [2];
  logic [1:0]            full;
  ch_e                   ptr;
  logic signed [W-1:0]   i1 [2];
  logic signed [W-1:0]   i2 [2];
  logic [1:0]            y;

  logic                  toggle;
  logic                  rise;
  logic                  fall;
  logic                  boundary;
  logic                  accept;
  logic                  step;
  logic                  missing;
  logic [1:0]            active;
  logic [1:0]            load;
  ch_e                   sel;
  logic signed [DATA_WIDTH-1:0] x;
  logic signed [W-1:0]   i1_next;
  logic signed [W-1:0]   i2_next;
  logic                  y_next;

  // The first rise after enable is always a boundary so sample 0 (or an
  // underrun) is resolved there; later boundaries follow every os rises.
  always_comb begin
    toggle           = (div_cnt >= cfg_clkdiv_i);
    rise             = toggle & ~pdm_clk_o;
    fall             = toggle & pdm_clk_o;
    os_last          = (cfg_oversample_i == '0) ? '0 : cfg_oversample_i - 10'd1;
    boundary         = rise & (~started | (os_cnt >= os_last));
    active           = {cfg_stereo_i, 1'b1};
    load             = boundary ? (active & full) : '0;
    missing          = boundary & ((active & ~full) != '0);
    pcm_data_ready_o = cfg_en_i & ~full[ptr];
    accept           = pcm_data_valid_i & pcm_data_ready_o;
    sel              = (fall & cfg_stereo_i) ? CH1 : CH0;
    step             = rise | (fall & cfg_stereo_i);
    x                = (sel == CH0 && load[CH0]) ? nxt[CH0] : cur[sel];
  end

  pdm_sd2_mod #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_EXT   (ACC_EXT)
  ) u_mod (
    .x      (x),
    .i1     (i1[sel]),
    .i2     (i2[sel]),
    .y      (y[sel]),
    .i1_next(i1_next),
    .i2_next(i2_next),
    .y_next (y_next)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_cnt    <= '0;
      os_cnt     <= '0;
      started    <= 1'b0;
      pdm_clk_o  <= 1'b0;
      pdm_data_o <= 1'b0;
      underrun_o <= 1'b0;
      cur        <= '{default: '0};
      nxt        <= '{default: '0};
      full       <= '0;
      ptr        <= CH0;
      i1         <= '{default: '0};
      i2         <= '{default: '0};
      y          <= '0;
    end else if (!cfg_en_i) begin
      div_cnt    <= '0;
      os_cnt     <= '0;
      started    <= 1'b0;
      pdm_clk_o  <= 1'b0;
      pdm_data_o <= 1'b0;
      underrun_o <= 1'b0;
      cur        <= '{default: '0};
      nxt        <= '{default: '0};
      full       <= '0;
      ptr        <= CH0;
      i1         <= '{default: '0};
      i2         <= '{default: '0};
      y          <= '0;
    end else begin
      if (toggle) begin
        div_cnt   <= '0;
        pdm_clk_o <= ~pdm_clk_o;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (rise) begin
        started <= 1'b1;
        os_cnt  <= boundary ? '0 : os_cnt + 10'd1;
      end
      underrun_o <= missing;
      for (int unsigned c = 0; c < 2; c++) begin
        if (load[c]) begin
          cur[c]  <= nxt[c];
          full[c] <= 1'b0;
        end
      end
      // Acceptance needs full[ptr] clear, so it never collides with a load.
      if (accept) begin
        nxt[ptr]  <= pcm_data_i;
        full[ptr] <= 1'b1;
        if (cfg_stereo_i) ptr <= (ptr == CH0) ? CH1 : CH0;
      end
      if (step) begin
        i1[sel]    <= i1_next;
        i2[sel]    <= i2_next;
        y[sel]     <= y_next;
        pdm_data_o <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_pdm_tx.sv
// Self-checking bench for pdm_tx against a cycle-arithmetic reference model.
module tb_pdm_tx;

  localparam longint FS  = 32768;
  localparam longint LIM = (longint'(1) <<< 19) - 1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        stereo;
  logic [7:0]  clkdiv;
  logic [9:0]  osr;
  logic [15:0] pdata;
  logic        pvalid;
  logic        pready;
  logic        pclk;
  logic        pdm;
  logic        unr;

  always #5 clk = ~clk;

  pdm_tx #(
    .DATA_WIDTH(16),
    .ACC_EXT   (4)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .cfg_en_i        (en),
    .cfg_stereo_i    (stereo),
    .cfg_clkdiv_i    (clkdiv),
    .cfg_oversample_i(osr),
    .pcm_data_i      (pdata),
    .pcm_data_valid_i(pvalid),
    .pcm_data_ready_o(pready),
    .pdm_clk_o       (pclk),
    .pdm_data_o      (pdm),
    .underrun_o      (unr)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int unsigned m_cyc;
  bit          m_full [2];
  logic [15:0] m_nxt [2];
  logic [15:0] m_cur [2];
  bit          m_ptr;
  longint      m_i1 [2];
  longint      m_i2 [2];
  bit          m_y [2];
  bit          e_clk, e_data, e_unr, last_acc;

  logic [15:0] samp [512];
  int          src_idx;
  logic        hist_hi [$];
  logic        hist_lo [$];
  logic        prev_clk;
  logic        ref_bits [160];
  bit          vpat [160];
  int          first_rise, second_rise, bad, ones, zeros, acc_n, cnt, dbl, diffs;
  logic        p_clk, p_pdm, p_unr;

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    checks++;
    assert (v >= lo && v <= hi) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  task automatic m_clear();
    m_cyc = 0; m_ptr = 0;
    e_clk = 0; e_data = 0; e_unr = 0;
    for (int c = 0; c < 2; c++) begin
      m_full[c] = 0; m_nxt[c] = '0; m_cur[c] = '0;
      m_i1[c] = 0; m_i2[c] = 0; m_y[c] = 0;
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  task automatic sd_step(input int c, output bit yb);
    longint xv, fb;
    xv = longint'($signed(m_cur[c]));
    fb = m_y[c] ? FS : -FS;
    m_i1[c] = sat(m_i1[c] + xv - fb);
    m_i2[c] = sat(m_i2[c] + m_i1[c] - fb);
    m_y[c]  = (m_i2[c] >= 0);
    yb = m_y[c];
  endtask

  // Toggles happen at enabled cycles n*(clkdiv+1); odd n are rises, rise r
  // is a boundary when (r-1) is a multiple of the oversample ratio.
  task automatic model_edge();
    int unsigned per, k, r, os;
    bit yb;
    last_acc = 0;
    if (!rstn || !en) begin
      m_clear();
      return;
    end
    last_acc = pvalid && !m_full[m_ptr];
    m_cyc++;
    e_unr = 0;
    k = 0;
    per = clkdiv + 1;
    os = (osr == 0) ? 1 : osr;
    if (m_cyc % per == 0) begin
      k = m_cyc / per;
      e_clk = k[0];
      if (k[0]) begin
        r = (k + 1) / 2;
        if ((r - 1) % os == 0) begin
          for (int c = 0; c < 2; c++) begin
            if (c == 0 || stereo) begin
              if (m_full[c]) begin
                m_cur[c] = m_nxt[c];
                m_full[c] = 0;
              end else begin
                e_unr = 1;
              end
            end
          end
        end
      end
    end
    if (last_acc) begin
      m_nxt[m_ptr] = pdata;
      m_full[m_ptr] = 1;
      if (stereo) m_ptr = !m_ptr;
    end
    if (m_cyc % per == 0) begin
      if (k[0]) begin
        sd_step(0, yb);
        e_data = yb;
      end else if (stereo) begin
        sd_step(1, yb);
        e_data = yb;
      end
    end
  endtask

  task automatic tick();
    #1;
    chk("ready", pready, en && !m_full[m_ptr]);
    model_edge();
    @(posedge clk);
    #1;
    chk("pdm_clk", pclk, e_clk);
    chk("pdm_data", pdm, e_data);
    chk("underrun", unr, e_unr);
    if (pclk && !prev_clk) hist_hi.push_back(pdm);
    if (!pclk && prev_clk) hist_lo.push_back(pdm);
    prev_clk = pclk;
    if (last_acc) src_idx = (src_idx + 1) % 512;
    pdata = samp[src_idx];
  endtask

  task automatic restart();
    en = 0;
    tick();
    src_idx = 0;
    pdata = samp[0];
    hist_hi.delete();
    hist_lo.delete();
  endtask

  task automatic dc_test(input logic [15:0] val, input int lo, input int hi);
    restart();
    for (int i = 0; i < 512; i++) samp[i] = val;
    pdata = val; stereo = 0; clkdiv = 8'd1; osr = 10'd64; pvalid = 1; en = 1;
    repeat (600) tick();
    chk_rng($sformatf("dc_%h_rises", val), hist_hi.size(), 136, 200);
    for (int w = 8; w <= 72; w += 32) begin
      ones = 0;
      for (int i = w; i < w + 64; i++) if (i < hist_hi.size() && hist_hi[i] === 1'b1) ones++;
      chk_rng($sformatf("dc_%h_ones_at_%0d", val, w), ones, lo, hi);
    end
  endtask

  initial begin
    m_clear();
    prev_clk = 0; src_idx = 0;
    for (int i = 0; i < 512; i++) samp[i] = 16'h1234;
    rstn = 0; en = 0; stereo = 0; clkdiv = 8'd1; osr = 10'd64;
    pdata = 16'h1234; pvalid = 1;

    // reset held, then released with enable low
    repeat (3) tick();
    chk("rst_ready", pready, 1'b0);
    rstn = 1;
    repeat (3) tick();
    chk("idle_clk", pclk, 1'b0);

    // clock generation: half period clkdiv+1, first rise on cycle 2
    for (int i = 0; i < 512; i++) samp[i] = 16'h0000;
    src_idx = 0; pdata = '0; clkdiv = 8'd1; osr = 10'd4; en = 1;
    first_rise = 0; second_rise = 0; bad = 0; p_clk = 0; p_pdm = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (pclk && !p_clk) begin
        if (first_rise == 0) first_rise = i;
        else if (second_rise == 0) second_rise = i;
      end
      if (pdm !== p_pdm && !(pclk && !p_clk)) bad++;
      p_clk = pclk; p_pdm = pdm;
    end
    chk32("first_rise", first_rise, 2);
    chk32("pdm_period", second_rise - first_rise, 4);
    chk32("data_only_at_rise", bad, 0);

    // mono DC densities
    dc_test(16'h0000, 32, 32);
    dc_test(16'h4000, 47, 49);
    dc_test(16'h7FFF, 62, 64);

    // underrun: two samples then the source stops
    restart();
    samp[0] = 16'($urandom); samp[1] = 16'($urandom);
    samp[2] = 16'($urandom);
    pdata = samp[0]; stereo = 0; clkdiv = 8'd1; osr = 10'd4; pvalid = 1; en = 1;
    acc_n = 0;
    for (int i = 0; i < 10 && acc_n < 2; i++) begin
      tick();
      if (last_acc) acc_n++;
    end
    chk32("underrun_accepts", acc_n, 2);
    pvalid = 0; cnt = 0; dbl = 0; p_unr = 0;
    repeat (80) begin
      tick();
      if (unr === 1'b1) cnt++;
      if (unr === 1'b1 && p_unr === 1'b1) dbl++;
      p_unr = unr;
    end
    chk32("underrun_pulses", cnt, 4);
    chk32("underrun_width", dbl, 0);

    // stereo: ch0 full positive, ch1 full negative
    restart();
    for (int i = 0; i < 512; i++) samp[i] = i[0] ? 16'h8000 : 16'h7FFF;
    pdata = samp[0]; stereo = 1; clkdiv = 8'd1; osr = 10'd8; pvalid = 1; en = 1;
    repeat (140) tick();
    chk_rng("stereo_accepts", src_idx, 4, 200);
    ones = 0; zeros = 0;
    for (int i = 12; i < 28; i++) begin
      if (i < hist_hi.size() && hist_hi[i] === 1'b1) ones++;
      if (i < hist_lo.size() && hist_lo[i] === 1'b0) zeros++;
    end
    chk_rng("stereo_high_ones", ones, 14, 16);
    chk_rng("stereo_low_zeros", zeros, 14, 16);

    // disable mid-stream and rerun with identical input
    restart();
    for (int i = 0; i < 512; i++) samp[i] = 16'($urandom);
    for (int i = 0; i < 160; i++) vpat[i] = ($urandom_range(0, 1) == 1);
    pdata = samp[0]; stereo = 0; clkdiv = 8'd0; osr = 10'd2; en = 1;
    for (int i = 0; i < 160; i++) begin
      pvalid = vpat[i];
      tick();
      ref_bits[i] = e_data;
    end
    en = 0;
    tick();
    chk("dis_clk", pclk, 1'b0);
    chk("dis_data", pdm, 1'b0);
    chk("dis_underrun", unr, 1'b0);
    chk("dis_ready", pready, 1'b0);
    src_idx = 0; pdata = samp[0]; en = 1; diffs = 0;
    for (int i = 0; i < 160; i++) begin
      pvalid = vpat[i];
      tick();
      if (pdm !== ref_bits[i]) diffs++;
    end
    chk32("rerun_diffs", diffs, 0);

    // randomized configurations and traffic
    for (int it = 0; it < 6; it++) begin
      restart();
      for (int i = 0; i < 512; i++) samp[i] = 16'($urandom);
      pdata = samp[0];
      clkdiv = 8'($urandom_range(0, 3));
      osr = 10'($urandom_range(0, 5));
      stereo = 1'($urandom_range(0, 1));
      en = 1;
      repeat (250) begin
        pvalid = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    en = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
